// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes NS/EW light buses into phases; checks conflicts, codes, order and dwell (dwell checks need `TLC_MON_TIMING_EN).
// Latency: a sample registered at edge N shows on all outputs after edge N+1.
// Backpressure: none; the monitor observes every cycle and never stalls.
module traffic_light_monitor #(
  parameter int EXP_DWELL = 101,
  parameter int DWELL_TOL = 0,
  parameter int DW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    light_NS,
  input  logic [2:0]    light_EW,
  input  logic          err_clr,
  output logic [1:0]    phase,
  output logic          phase_vld,
  output logic          locked,
  output logic          conflict_err,
  output logic          code_err,
  output logic          seq_err,
  output logic          timing_err,
  output logic [3:0]    err_flags,
  output logic [DW-1:0] dwell,
  output logic [15:0]   cycle_cnt
);

  localparam logic [0:0] ST_ACQ = 1'b0;
  localparam logic [0:0] ST_TRK = 1'b1;

  logic [2:0]  r_in_ns;
  logic [2:0]  r_in_ew;
  logic        r_in_vld;
  logic [0:0]  r_state;
  logic        r_ref_vld;
  logic [1:0]  r_phase;
  logic        r_phase_vld;
  logic        r_conflict;
  logic        r_code;
  logic        r_seq;
  logic        r_timing;
  logic [3:0]  r_err_flags;
  logic [15:0] r_cycle_cnt;

  logic        w_legal;
  logic [1:0]  w_dec;
  logic        w_conflict;
  logic        w_code;
  logic        w_sample;
  logic        w_change;
  logic        w_succ;
  logic        w_seq;
  logic        w_timing;
  logic        w_stuck;

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 2'd0;
    case ({r_in_ns, r_in_ew})
      6'b001_100: w_dec = 2'd0;
      6'b010_100: w_dec = 2'd1;
      6'b100_001: w_dec = 2'd2;
      6'b100_010: w_dec = 2'd3;
      default:    w_legal = 1'b0;
    endcase
  end

  // r_in_vld masks the reset value of in_q, which is all-red but not a real sample
  assign w_conflict = r_in_vld && !r_in_ns[2] && !r_in_ew[2];
  assign w_code     = r_in_vld && !w_legal && !w_conflict;
  assign w_sample   = r_in_vld && w_legal;
  assign w_change   = w_sample && r_ref_vld && (w_dec != r_phase);
  assign w_succ     = (w_dec == r_phase + 2'd1);
  assign w_seq      = w_change && (r_state == ST_TRK) && !w_succ;

`ifdef TLC_MON_TIMING_EN
  localparam int DW_LO = EXP_DWELL - DWELL_TOL;
  localparam int DW_HI = EXP_DWELL + DWELL_TOL;

  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell_inc;

  assign w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + DW'(1);
  assign w_stuck     = w_sample && r_ref_vld && !w_change && (r_state == ST_TRK) &&
                       (int'(w_dwell_inc) == DW_HI + 1);
  assign w_timing    = (w_change && (r_state == ST_TRK) &&
                        ((int'(r_dwell) < DW_LO) || (int'(r_dwell) > DW_HI))) || w_stuck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dwell <= '0;
    end else if (r_in_vld) begin
      if (!w_legal) begin
        r_dwell <= '0;
      end else if (w_change || !r_ref_vld) begin
        r_dwell <= DW'(1);
      end else begin
        r_dwell <= w_dwell_inc;
      end
    end
  end

  assign dwell = r_dwell;
`else
  logic [DW-1:0] w_unused_cfg;

  assign w_unused_cfg = DW'(EXP_DWELL + DWELL_TOL);
  assign w_stuck      = 1'b0;
  assign w_timing     = 1'b0;
  assign dwell        = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ns     <= 3'b100;
      r_in_ew     <= 3'b100;
      r_in_vld    <= 1'b0;
      r_state     <= ST_ACQ;
      r_ref_vld   <= 1'b0;
      r_phase     <= 2'd0;
      r_phase_vld <= 1'b0;
      r_conflict  <= 1'b0;
      r_code      <= 1'b0;
      r_seq       <= 1'b0;
      r_timing    <= 1'b0;
      r_err_flags <= 4'b0000;
      r_cycle_cnt <= 16'd0;
    end else begin
      r_in_ns     <= light_NS;
      r_in_ew     <= light_EW;
      r_in_vld    <= 1'b1;
      r_phase_vld <= w_sample;
      r_conflict  <= w_conflict;
      r_code      <= w_code;
      r_seq       <= w_seq;
      r_timing    <= w_timing;
      // a new pulse wins over a simultaneous clear
      r_err_flags <= (err_clr ? 4'b0000 : r_err_flags) | {w_timing, w_seq, w_code, w_conflict};

      if (w_sample) begin
        r_phase   <= w_dec;
        r_ref_vld <= 1'b1;
      end

      if (r_in_vld && !w_legal) begin
        r_state <= ST_ACQ;
      end else if (w_change) begin
        r_state <= w_succ ? ST_TRK : ST_ACQ;
      end else if (w_stuck) begin
        r_state <= ST_ACQ;
      end

      if (w_change && (r_state == ST_TRK) && w_succ && (r_phase == 2'd3)) begin
        r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end
    end
  end

  assign phase        = r_phase;
  assign phase_vld    = r_phase_vld;
  assign locked       = (r_state == ST_TRK);
  assign conflict_err = r_conflict;
  assign code_err     = r_code;
  assign seq_err      = r_seq;
  assign timing_err   = r_timing;
  assign err_flags    = r_err_flags;
  assign cycle_cnt    = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: scenario tasks plus randomized phase streams against a phase-rule model.
module tb_traffic_light_monitor;

`ifdef TLC_MON_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif
  localparam int EXP = 101;
  localparam int TOL = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  light_NS = 3'b100;
  logic [2:0]  light_EW = 3'b100;
  logic        err_clr = 1'b0;
  logic [1:0]  phase;
  logic        phase_vld, locked, conflict_err, code_err, seq_err, timing_err;
  logic [3:0]  err_flags;
  logic [15:0] dwell;
  logic [15:0] cycle_cnt;

  traffic_light_monitor #(.EXP_DWELL(EXP), .DWELL_TOL(TOL), .DW(16)) dut (
    .clk(clk), .reset(reset), .light_NS(light_NS), .light_EW(light_EW), .err_clr(err_clr),
    .phase(phase), .phase_vld(phase_vld), .locked(locked), .conflict_err(conflict_err),
    .code_err(code_err), .seq_err(seq_err), .timing_err(timing_err), .err_flags(err_flags),
    .dwell(dwell), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [2:0] pns_tab [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] pew_tab [4] = '{3'b100, 3'b100, 3'b001, 3'b010};

  // model of the monitor's visible state, driven by the phase rules
  int       m_ref, m_dwell, m_cyc;
  bit       m_locked, m_vld, m_skip;
  bit [3:0] m_flags, m_pulse;
  logic [2:0] p_ns = 3'b100;
  logic [2:0] p_ew = 3'b100;

  logic [43:0] obs_vec;
  assign obs_vec = {phase, phase_vld, locked, timing_err, seq_err, code_err, conflict_err,
                    err_flags, dwell, cycle_cnt};

  function automatic int decode(input logic [2:0] ns, input logic [2:0] ew);
    for (int i = 0; i < 4; i++) if (ns == pns_tab[i] && ew == pew_tab[i]) return i;
    return -1;
  endfunction

  function automatic logic [43:0] model_out();
    return {2'(m_ref < 0 ? 0 : m_ref), m_vld, m_locked, m_pulse, m_flags,
            16'(TIMING ? m_dwell : 0), 16'(m_cyc)};
  endfunction

  task automatic model_reset();
    m_ref = -1; m_dwell = 0; m_cyc = 0; m_locked = 0; m_vld = 0;
    m_flags = 4'b0; m_pulse = 4'b0; m_skip = 1;
  endtask

  task automatic model_step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
    int p;
    bit seq, tim;
    p = decode(ns, ew);
    m_pulse = 4'b0; seq = 0; tim = 0;
    if (m_skip) begin
      m_skip = 0; m_vld = 0;
    end else if (p < 0) begin
      m_vld = 0; m_locked = 0; m_dwell = 0;
      if (!ns[2] && !ew[2]) m_pulse[0] = 1'b1; else m_pulse[1] = 1'b1;
    end else begin
      m_vld = 1;
      if (m_ref < 0) begin
        m_dwell = 1;
      end else if (p == m_ref) begin
        if (m_dwell < 65535) m_dwell++;
        if (TIMING && m_locked && m_dwell == EXP + TOL + 1) begin tim = 1; m_locked = 0; end
      end else begin
        if (m_locked) begin
          seq = (p != (m_ref + 1) % 4);
          tim = TIMING && (m_dwell < EXP - TOL || m_dwell > EXP + TOL);
          if (m_ref == 3 && p == 0) m_cyc = (m_cyc + 1) % 65536;
          m_locked = !seq;
        end else begin
          m_locked = (p == (m_ref + 1) % 4);
        end
        m_dwell = 1;
      end
      m_ref = p;
    end
    m_pulse[2] = seq; m_pulse[3] = tim;
    m_flags = (clr ? 4'b0 : m_flags) | m_pulse;
  endtask

  // drive one sample, clock it, advance the model by the previously captured sample
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
    light_NS = ns; light_EW = ew; err_clr = clr;
    @(posedge clk);
    model_step(p_ns, p_ew, clr);
    p_ns = ns; p_ew = ew;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_vec !== 44'd0) begin bad++; $display("FAIL reset_state: got %h want 0", obs_vec); end
    reset = 0;
    model_reset();
    for (int j = 0; j < 3; j++) begin
      step(pns_tab[0], pew_tab[0], 1'b0);
      total++;
      if (obs_vec !== model_out()) begin
        bad++; $display("FAIL reset_first j%0d: got %h want %h", j, obs_vec, model_out());
      end
    end
  endtask

  task automatic test_clean();
    int maxd = 0;
    int pulses = 0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        for (int j = 0; j < EXP; j++) begin
          step(pns_tab[p], pew_tab[p], 1'b0);
          total++;
          if (obs_vec !== model_out()) begin
            bad++; $display("FAIL clean r%0d p%0d j%0d: got %h want %h", r, p, j, obs_vec, model_out());
          end
          if (r == 1 && int'(dwell) > maxd) maxd = int'(dwell);
          if (conflict_err | code_err | seq_err | timing_err) pulses++;
          if (r == 0 && p == 1 && j < 2) begin
            total++;
            if (locked !== (j == 1)) begin
              bad++; $display("FAIL clean_lock_rise j%0d: got %b want %b", j, locked, (j == 1));
            end
          end
        end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL clean_no_err: got %0d pulses want 0", pulses); end
    total++;
    if (cycle_cnt !== 16'd1) begin bad++; $display("FAIL clean_cycle_cnt: got %0d want 1", cycle_cnt); end
    total++;
    if (maxd != (TIMING ? EXP : 0)) begin
      bad++; $display("FAIL clean_dwell_peak: got %0d want %0d", maxd, (TIMING ? EXP : 0));
    end
  endtask

  task automatic test_conflict();
    for (int j = 0; j < EXP + 7; j++) begin
      if (j == EXP) step(3'b001, 3'b001, 1'b0);
      else step(pns_tab[0], pew_tab[0], 1'b0);
      total++;
      if (obs_vec !== model_out()) begin
        bad++; $display("FAIL conflict j%0d: got %h want %h", j, obs_vec, model_out());
      end
      if (j == EXP + 1) begin
        total++;
        if ({conflict_err, err_flags, locked, phase_vld} !== 7'b1_0001_0_0) begin
          bad++; $display("FAIL conflict_pulse: got %b want 1000100", {conflict_err, err_flags, locked, phase_vld});
        end
      end
      if (j == EXP + 2) begin
        total++;
        if (conflict_err !== 1'b0) begin bad++; $display("FAIL conflict_width: got %b want 0", conflict_err); end
      end
    end
  endtask

  task automatic test_skip();
    int seg_ph [6] = '{1, 2, 3, 0, 2, 3};
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < EXP; j++) begin
        step(pns_tab[seg_ph[k]], pew_tab[seg_ph[k]], (k == 0 && j == 0));
        total++;
        if (obs_vec !== model_out()) begin
          bad++; $display("FAIL skip k%0d j%0d: got %h want %h", k, j, obs_vec, model_out());
        end
        if (k == 4 && j == 1) begin
          total++;
          if ({seq_err, err_flags[2], locked} !== 3'b110) begin
            bad++; $display("FAIL skip_seq: got %b want 110", {seq_err, err_flags[2], locked});
          end
        end
        if (k == 5 && j == 1) begin
          total++;
          if (locked !== 1'b1) begin bad++; $display("FAIL skip_relock: got %b want 1", locked); end
        end
      end
  endtask

  task automatic test_timing();
    int seg_ph [5] = '{0, 1, 2, 3, 0};
    int seg_len [5] = '{101, 90, 200, 101, 101};
    int tpulses = 0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < seg_len[k]; j++) begin
        step(pns_tab[seg_ph[k]], pew_tab[seg_ph[k]], (k == 0 && j == 0));
        total++;
        if (obs_vec !== model_out()) begin
          bad++; $display("FAIL timing k%0d j%0d: got %h want %h", k, j, obs_vec, model_out());
        end
        if (k == 2 && j == 1) begin
          total++;
          if ({timing_err, locked} !== {TIMING, 1'b1}) begin
            bad++; $display("FAIL timing_short: got %b want %b", {timing_err, locked}, {TIMING, 1'b1});
          end
        end
        if (k == 2 && j >= 2 && timing_err) tpulses++;
        if (k == 2 && j == 102) begin
          total++;
          if ({timing_err, locked, dwell} !== {TIMING, !TIMING, 16'(TIMING ? 102 : 0)}) begin
            bad++; $display("FAIL timing_stuck: got %b %b %0d want %b %b %0d", timing_err, locked, dwell,
                            TIMING, !TIMING, (TIMING ? 102 : 0));
          end
        end
      end
    total++;
    if (tpulses != (TIMING ? 1 : 0)) begin
      bad++; $display("FAIL timing_stuck_once: got %0d want %0d", tpulses, (TIMING ? 1 : 0));
    end
  endtask

  task automatic test_clear_reset();
    step(3'b100, 3'b100, 1'b0);
    step(pns_tab[0], pew_tab[0], 1'b1);
    total++;
    if ({code_err, err_flags} !== 5'b1_0010) begin
      bad++; $display("FAIL clear_vs_set: got %b want 10010", {code_err, err_flags});
    end
    for (int j = 0; j < 20; j++) begin
      step(pns_tab[0], pew_tab[0], 1'b0);
      total++;
      if (obs_vec !== model_out()) begin
        bad++; $display("FAIL clear j%0d: got %h want %h", j, obs_vec, model_out());
      end
    end
    #2 reset = 1;
    #1;
    total++;
    if (obs_vec !== 44'd0) begin bad++; $display("FAIL mid_reset: got %h want 0", obs_vec); end
    @(posedge clk);
    #1 reset = 0;
    model_reset();
    for (int j = 0; j < 6; j++) begin
      step(pns_tab[1], pew_tab[1], 1'b0);
      total++;
      if (obs_vec !== model_out()) begin
        bad++; $display("FAIL after_reset j%0d: got %h want %h", j, obs_vec, model_out());
      end
    end
  endtask

  task automatic test_random();
    int ph = 1;
    for (int s = 0; s < 25; s++) begin
      int len;
      int r;
      len = $urandom_range(95, 106);
      r = $urandom_range(0, 9);
      if (r == 0) ph = $urandom_range(0, 3); else ph = (ph + 1) % 4;
      if (r == 1) len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        logic [2:0] ns;
        logic [2:0] ew;
        logic c;
        ns = pns_tab[ph]; ew = pew_tab[ph];
        c = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 199) == 0) begin ns = 3'($urandom); ew = 3'($urandom); end
        step(ns, ew, c);
        total++;
        if (obs_vec !== model_out()) begin
          bad++; $display("FAIL random s%0d j%0d: got %h want %h", s, j, obs_vec, model_out());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean();
    test_conflict();
    test_skip();
    test_timing();
    test_clear_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
